// File: rtl/array_reduce_engine_pkg.sv
// Shared types and helpers for the array reduce engine: operation and state
// encodings, accumulator identities and the write-back saturator.
package array_reduce_engine_pkg;

    typedef enum logic [1:0] {
        MODE_SUM    = 2'd0,
        MODE_MIN    = 2'd1,
        MODE_MAX    = 2'd2,
        MODE_PREFIX = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACC  = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Widths up to 64 bits; callers truncate to their own width.
    function automatic logic [63:0] max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] min_neg(input int w);
        return ~max_pos(w);
    endfunction

    function automatic logic [63:0] ident_for_mode(input mode_e m, input int w);
        case (m)
            MODE_MIN: return max_pos(w);
            MODE_MAX: return min_neg(w);
            default:  return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] sat_to_width(input logic signed [63:0] v, input int w,
                                                 output logic clipped);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = $signed(max_pos(w));
        lo = $signed(min_neg(w));
        clipped = 1'b0;
        if (v > hi) begin
            clipped = 1'b1;
            return hi;
        end
        if (v < lo) begin
            clipped = 1'b1;
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/array_reduce_engine_reduce_alu.sv
// Combinational reduction step: folds one sign-extended element into the
// accumulator for SUM/PREFIX (wrapping add) or MIN/MAX (signed compare).
module array_reduce_engine_reduce_alu import array_reduce_engine_pkg::*; #(
    parameter int ACC_W = 16
) (
    input  mode_e                   mode,
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [ACC_W-1:0] elem,
    output logic signed [ACC_W-1:0] acc_next,
    output logic                    ovf
);

    logic signed [ACC_W-1:0] sum;

    always_comb begin
        sum      = acc + elem;
        acc_next = acc;
        ovf      = 1'b0;
        case (mode)
            // Strict compares so ties keep the older value.
            MODE_MIN: if (elem < acc) acc_next = elem;
            MODE_MAX: if (elem > acc) acc_next = elem;
            default: begin
                acc_next = sum;
                ovf      = (acc[ACC_W-1] == elem[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
            end
        endcase
    end

endmodule

// File: rtl/array_reduce_engine.sv
// Walks a window of a synchronous array RAM and reduces it (SUM/MIN/MAX) or
// rewrites it in place as a saturated prefix sum.
module array_reduce_engine import array_reduce_engine_pkg::*; #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 5,
    parameter int ACC_W   = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic [ADDR_W:0]   index,
    output logic              ovf,
    output logic              sat,
    output logic              err
);

    localparam int            DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [ADDR_W:0]         len_q, len_d, index_d, index_inc;
    logic signed [ACC_W-1:0] acc_q, acc_d, alu_next, elem_ext;
    logic                    alu_ovf;
    logic [ADDR_W-1:0]       mem_addr_d;
    logic                    mem_wren_d;
    logic [DATA_W-1:0]       mem_wdata_d;
    logic [ACC_W-1:0]        result_d;
    logic                    ovf_d, sat_d, err_d;
    logic signed [63:0]      acc_wide;
    logic                    clip;

    assign elem_ext = ACC_W'($signed(mem_rdata));

    array_reduce_engine_reduce_alu #(.ACC_W(ACC_W)) u_alu (
        .mode     (mode_q),
        .acc      (acc_q),
        .elem     (elem_ext),
        .acc_next (alu_next),
        .ovf      (alu_ovf)
    );

    assign busy = (state_q == ST_RD) || (state_q == ST_WAIT) ||
                  (state_q == ST_ACC) || (state_q == ST_WR);
    assign done = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_SUM;
            len_q     <= '0;
            acc_q     <= '0;
            index     <= '0;
            mem_addr  <= '0;
            mem_wren  <= 1'b0;
            mem_wdata <= '0;
            result    <= '0;
            ovf       <= 1'b0;
            sat       <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            acc_q     <= acc_d;
            index     <= index_d;
            mem_addr  <= mem_addr_d;
            mem_wren  <= mem_wren_d;
            mem_wdata <= mem_wdata_d;
            result    <= result_d;
            ovf       <= ovf_d;
            sat       <= sat_d;
            err       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        len_d       = len_q;
        acc_d       = acc_q;
        index_d     = index;
        index_inc   = index + (ADDR_W + 1)'(1);
        mem_addr_d  = mem_addr;
        mem_wren_d  = 1'b0;
        mem_wdata_d = mem_wdata;
        result_d    = result;
        ovf_d       = ovf;
        sat_d       = sat;
        err_d       = err;
        clip        = 1'b0;
        acc_wide    = 64'(alu_next);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ovf_d    = 1'b0;
                    sat_d    = 1'b0;
                    err_d    = 1'b0;
                    index_d  = '0;
                    result_d = '0;
                    mode_d   = mode_e'(mode);
                    len_d    = length;
                    if (length == '0) begin
                        acc_d   = ACC_W'(ident_for_mode(mode_e'(mode), ACC_W));
                        state_d = ST_DONE;
                    end else if (length > DEPTH_L) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        mem_addr_d = base_addr;
                        acc_d      = ACC_W'(ident_for_mode(mode_e'(mode), ACC_W));
                        state_d    = ST_RD;
                    end
                end
            end
            ST_RD:   state_d = (MEM_LAT == 2) ? ST_WAIT : ST_ACC;
            ST_WAIT: state_d = ST_ACC;
            ST_ACC: begin
                acc_d   = alu_next;
                index_d = index_inc;
                if (alu_ovf) ovf_d = 1'b1;
                if (mode_q == MODE_PREFIX) begin
                    // Write-back is registered so the RAM sees it during WR.
                    mem_wren_d  = 1'b1;
                    mem_wdata_d = DATA_W'(sat_to_width(acc_wide, DATA_W, clip));
                    if (clip) sat_d = 1'b1;
                    state_d = ST_WR;
                end else if (index_inc == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    mem_addr_d = mem_addr + ADDR_W'(1);
                    state_d    = ST_RD;
                end
            end
            ST_WR: begin
                if (index == len_q) begin
                    state_d = ST_DONE;
                end else begin
                    mem_addr_d = mem_addr + ADDR_W'(1);
                    state_d    = ST_RD;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Result is published on the same edge that enters DONE.
        if (state_d == ST_DONE && state_q != ST_DONE) result_d = acc_d;
    end

endmodule

// File: tb/tb_array_reduce_engine.sv
// Directed bench for array_reduce_engine: default build with a 1-cycle RAM,
// plus MEM_LAT=2 builds at ACC_W=16 and ACC_W=12 sharing one stimulus.
module tb_array_reduce_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   failures = 0;

    // Instance A: defaults
    logic       a_start;
    logic [1:0] a_mode;
    logic [4:0] a_base;
    logic [5:0] a_len;
    logic [4:0] a_addr;
    logic [7:0] a_rdata;
    logic       a_wren;
    logic [7:0] a_wdata;
    logic       a_busy, a_done, a_ovf, a_sat, a_err;
    logic [15:0] a_result;
    logic [5:0] a_index;

    array_reduce_engine u_a (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .base_addr(a_base),
        .length(a_len), .mem_addr(a_addr), .mem_rdata(a_rdata), .mem_wren(a_wren),
        .mem_wdata(a_wdata), .busy(a_busy), .done(a_done), .result(a_result),
        .index(a_index), .ovf(a_ovf), .sat(a_sat), .err(a_err)
    );

    logic [7:0] ram_a [0:31];
    logic       ld_en;
    logic [4:0] ld_addr;
    logic [7:0] ld_data;
    always @(posedge clk) begin
        a_rdata <= ram_a[a_addr];
        if (a_wren === 1'b1) ram_a[a_addr] <= a_wdata;
        else if (ld_en) ram_a[ld_addr] <= ld_data;
    end

    int         wr_cnt;
    logic       wr_clr;
    logic [4:0] wr_addr_log [0:7];
    logic [7:0] wr_data_log [0:7];
    always @(posedge clk) begin
        if (wr_clr) wr_cnt <= 0;
        else if (a_wren === 1'b1) begin
            if (wr_cnt < 8) begin
                wr_addr_log[wr_cnt[2:0]] <= a_addr;
                wr_data_log[wr_cnt[2:0]] <= a_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Instances B (ACC_W=16) and C (ACC_W=12), MEM_LAT=2, RAM all 127
    logic       b_start;
    logic [1:0] b_mode;
    logic [4:0] b_base;
    logic [5:0] b_len;
    logic [7:0] b_s1, b_rdata;
    logic [4:0] b_addr, c_addr;
    logic       b_wren, c_wren;
    logic [7:0] b_wdata, c_wdata;
    logic       b_busy, b_done, b_ovf, b_sat, b_err;
    logic       c_busy, c_done, c_ovf, c_sat, c_err;
    logic [15:0] b_result;
    logic [11:0] c_result;
    logic [5:0] b_index, c_index;

    always @(posedge clk) begin
        if (rst) begin
            b_s1    <= 8'd0;
            b_rdata <= 8'd0;
        end else begin
            b_s1    <= 8'd127;
            b_rdata <= b_s1;
        end
    end

    array_reduce_engine #(.MEM_LAT(2)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .base_addr(b_base),
        .length(b_len), .mem_addr(b_addr), .mem_rdata(b_rdata), .mem_wren(b_wren),
        .mem_wdata(b_wdata), .busy(b_busy), .done(b_done), .result(b_result),
        .index(b_index), .ovf(b_ovf), .sat(b_sat), .err(b_err)
    );

    array_reduce_engine #(.MEM_LAT(2), .ACC_W(12)) u_c (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .base_addr(b_base),
        .length(b_len), .mem_addr(c_addr), .mem_rdata(b_rdata), .mem_wren(c_wren),
        .mem_wdata(c_wdata), .busy(c_busy), .done(c_done), .result(c_result),
        .index(c_index), .ovf(c_ovf), .sat(c_sat), .err(c_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [4:0] ad, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = ad; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic clear_log();
        wr_clr = 1'b1;
        @(posedge clk); #1;
        wr_clr = 1'b0;
    endtask

    // Start a run on A; edges counts clock edges after the accepting edge
    // until done is seen. Inputs are scrambled after acceptance.
    task automatic run_a(input logic [1:0] m, input logic [4:0] b, input logic [5:0] l,
                         input int mid_at, output int edges, output int busyc);
        a_mode = m; a_base = b; a_len = l; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0; a_mode = 2'd0; a_base = 5'd7; a_len = 6'd1;
        edges = 0; busyc = 0;
        while (a_done !== 1'b1 && edges < 400) begin
            if (a_busy === 1'b1) busyc++;
            a_start = (edges == mid_at);
            @(posedge clk); #1;
            edges++;
        end
        a_start = 1'b0;
    endtask

    int   lat, bcy;
    logic found;

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_mode = 2'd0; a_base = 5'd0; a_len = 6'd0;
        b_start = 1'b0; b_mode = 2'd0; b_base = 5'd0; b_len = 6'd0;
        ld_en = 1'b0; ld_addr = 5'd0; ld_data = 8'd0; wr_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ctrl", 32'({a_busy, a_done, a_ovf, a_sat, a_err, a_wren}), 32'd0);
        chk("rst_a_result", 32'(a_result), 32'd0);
        chk("rst_a_index", 32'(a_index), 32'd0);
        chk("rst_a_addr_wdata", 32'({a_addr, a_wdata}), 32'd0);
        chk("rst_bc_ctrl", 32'({b_busy, b_done, b_ovf, b_sat, b_err, b_wren,
                                c_busy, c_done, c_ovf, c_sat, c_err, c_wren}), 32'd0);
        chk("rst_bc_data", 32'({b_wdata, c_wdata, b_result}), 32'd0);
        rst = 1'b0; wr_clr = 1'b0;

        load(5'd0, 8'd5); load(5'd1, 8'hFD); load(5'd2, 8'd7); load(5'd3, 8'd2);
        clear_log();

        run_a(2'd0, 5'd0, 6'd4, -1, lat, bcy);
        chk("sum_latency", 32'(lat), 32'd8);
        chk("sum_busy_cycles", 32'(bcy), 32'd8);
        chk("sum_result", 32'(a_result), 32'h000B);
        chk("sum_index", 32'(a_index), 32'd4);
        chk("sum_ovf", 32'(a_ovf), 32'd0);
        chk("sum_no_write", 32'(wr_cnt), 32'd0);
        @(posedge clk); #1;
        chk("sum_done_pulse", 32'({a_done, a_busy}), 32'd0);
        chk("sum_result_held", 32'(a_result), 32'h000B);

        run_a(2'd1, 5'd0, 6'd4, 3, lat, bcy);
        chk("min_latency", 32'(lat), 32'd8);
        chk("min_busy_cycles", 32'(bcy), 32'd8);
        chk("min_result", 32'(a_result), 32'h0000FFFD);
        @(posedge clk); #1;
        chk("min_mid_start_ignored", 32'({a_busy, a_done}), 32'd0);

        run_a(2'd2, 5'd0, 6'd4, 5, lat, bcy);
        chk("max_latency", 32'(lat), 32'd8);
        chk("max_result", 32'(a_result), 32'h0007);
        @(posedge clk); #1;

        run_a(2'd0, 5'd0, 6'd0, -1, lat, bcy);
        chk("len0_latency", 32'(lat), 32'd0);
        chk("len0_busy", 32'(bcy), 32'd0);
        chk("len0_sum_result", 32'(a_result), 32'd0);
        chk("len0_index", 32'(a_index), 32'd0);
        @(posedge clk); #1;
        run_a(2'd1, 5'd0, 6'd0, -1, lat, bcy);
        chk("len0_min_identity", 32'(a_result), 32'h7FFF);
        @(posedge clk); #1;
        run_a(2'd2, 5'd0, 6'd0, -1, lat, bcy);
        chk("len0_max_identity", 32'(a_result), 32'h8000);
        @(posedge clk); #1;

        run_a(2'd0, 5'd0, 6'd33, -1, lat, bcy);
        chk("len33_latency", 32'(lat), 32'd0);
        chk("len33_err", 32'(a_err), 32'd1);
        chk("len33_busy", 32'(bcy), 32'd0);
        chk("len33_result", 32'(a_result), 32'd0);
        chk("len0_len33_no_write", 32'(wr_cnt), 32'd0);
        @(posedge clk); #1;

        load(5'd30, 8'd100); load(5'd31, 8'd100); load(5'd0, 8'hCE); load(5'd1, 8'd10);
        clear_log();
        run_a(2'd3, 5'd30, 6'd4, -1, lat, bcy);
        chk("prefix_latency", 32'(lat), 32'd12);
        chk("prefix_busy_cycles", 32'(bcy), 32'd12);
        chk("prefix_result", 32'(a_result), 32'h00A0);
        chk("prefix_flags", 32'({a_sat, a_ovf, a_err}), 32'b100);
        chk("prefix_write_count", 32'(wr_cnt), 32'd4);
        chk("prefix_waddrs", 32'({wr_addr_log[0], wr_addr_log[1], wr_addr_log[2], wr_addr_log[3]}),
            32'({5'd30, 5'd31, 5'd0, 5'd1}));
        chk("prefix_wdata", 32'({wr_data_log[0], wr_data_log[1], wr_data_log[2], wr_data_log[3]}),
            32'h647F7F7F);
        @(posedge clk); #1;

        clear_log();
        a_mode = 2'd3; a_base = 5'd30; a_len = 6'd4; a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (a_wren === 1'b1 && wr_cnt == 1) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rstmid_second_wr_reached", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_ctrl", 32'({a_busy, a_done, a_wren, a_sat}), 32'd0);
        chk("rstmid_result", 32'(a_result), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_a(2'd0, 5'd0, 6'd2, -1, lat, bcy);
        chk("after_rst_latency", 32'(lat), 32'd4);
        chk("after_rst_result", 32'(a_result), 32'h00FE);

        b_mode = 2'd0; b_base = 5'd0; b_len = 6'd32; b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        lat = 0;
        while (b_done !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat2_latency", 32'(lat), 32'd96);
        chk("lat2_result", 32'(b_result), 32'h0FE0);
        chk("lat2_ovf", 32'(b_ovf), 32'd0);
        chk("lat2_index", 32'(b_index), 32'd32);
        chk("lat2_last_addr", 32'({b_addr, c_addr}), 32'({5'd31, 5'd31}));
        chk("acc12_done_together", 32'(c_done), 32'd1);
        chk("acc12_result", 32'(c_result), 32'hFE0);
        chk("acc12_ovf", 32'(c_ovf), 32'd1);
        chk("acc12_index", 32'(c_index), 32'd32);
        chk("bc_no_write", 32'({b_wren, c_wren, b_sat, c_sat, b_err, c_err, b_busy, c_busy}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
